q3_fn_bank: RTL and testbench

Registered bank of four fixed 4-input Boolean functions over inputs x, y, z, m. It provides the registered, clocked form of the q3 function set udp_q3_41, udp_q3_42, udp_q3_43 and udp_q3_44, plus a population count and a parity output. It sits between an input-capture stage and downstream logic that needs all function values of one input vector aligned on the same clock edge.

---
 rtl/q3_pkg.sv | 25 ++
 rtl/q3_fn_lut.sv | 16 +
 rtl/q3_fn_bank.sv | 100 ++++++++++
 tb/tb_q3_fn_bank.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/q3_pkg.sv
// q3_pkg: shared constants and types for the q3 function bank.
//   Q3_MASK_L1..Q3_MASK_L4 : 16-entry truth tables, bit i = f(n = i)
//   q3_idx_t               : 4-bit input index n = {x,y,z,m}
//   q3_cnt_t               : 3-bit population count 0..4
//   q3_popcount()          : ones count of an index
package q3_pkg;

  localparam logic [15:0] Q3_MASK_L1 = 16'h6996;  // odd parity
  localparam logic [15:0] Q3_MASK_L2 = 16'hE880;  // popcount >= 3
  localparam logic [15:0] Q3_MASK_L3 = 16'hF888;  // (x&y)|(z&m)
  localparam logic [15:0] Q3_MASK_L4 = 16'h28AC;  // prime index

  typedef logic [3:0] q3_idx_t;
  typedef logic [2:0] q3_cnt_t;

  function automatic q3_cnt_t q3_popcount(input q3_idx_t idx);
    q3_cnt_t cnt;
    cnt = '0;
    for (int unsigned i = 0; i < 4; i++) begin
      cnt = cnt + q3_cnt_t'(idx[i]);
    end
    return cnt;
  endfunction

endpackage

// File: rtl/q3_fn_lut.sv
// q3_fn_lut: combinational 16-entry lookup of one fixed Boolean function.
//   MASK  (param) : truth table, bit i = output for index i
//   i_idx (in, 4) : index n
//   o_f   (out,1) : MASK[n]
module q3_fn_lut
  import q3_pkg::*;
#(
  parameter logic [15:0] MASK = '0
) (
  input  q3_idx_t i_idx,
  output logic    o_f
);

  assign o_f = MASK[i_idx];

endmodule

// File: rtl/q3_fn_bank.sv
// q3_fn_bank: registered bank of the four q3 functions plus popcount/parity.
//   clk, rst_n (async, active-low)
//   in_valid, x, y, z, m : input vector n = {x,y,z,m}, qualified by in_valid
//   out_valid            : one-cycle pulse when l1..l4, s, p carry a new result
//   l1..l4               : udp_q3_41..44 of n ; s : popcount(n) ; p : = l1
//   err                  : sticky mismatch between mask lookup and gate-level
//                          evaluation; only built when Q3_XCHECK_EN is defined,
//                          otherwise tied low.
module q3_fn_bank
  import q3_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  input  logic       x,
  input  logic       y,
  input  logic       z,
  input  logic       m,
  output logic       out_valid,
  output logic       l1,
  output logic       l2,
  output logic       l3,
  output logic       l4,
  output logic [2:0] s,
  output logic       p,
  output logic       err
);

  q3_idx_t w_idx;
  logic    w_l1, w_l2, w_l3, w_l4;
  q3_cnt_t w_cnt;

  logic    r_valid;
  logic    r_l1, r_l2, r_l3, r_l4;
  q3_cnt_t r_s;

  assign w_idx = {x, y, z, m};
  assign w_cnt = q3_popcount(w_idx);

  q3_fn_lut #(.MASK(Q3_MASK_L1)) u_lut_l1 (.i_idx(w_idx), .o_f(w_l1));
  q3_fn_lut #(.MASK(Q3_MASK_L2)) u_lut_l2 (.i_idx(w_idx), .o_f(w_l2));
  q3_fn_lut #(.MASK(Q3_MASK_L3)) u_lut_l3 (.i_idx(w_idx), .o_f(w_l3));
  q3_fn_lut #(.MASK(Q3_MASK_L4)) u_lut_l4 (.i_idx(w_idx), .o_f(w_l4));

  // Valid is a pure pulse; result registers only load on a valid cycle so
  // they hold across idle cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
      r_l1    <= 1'b0;
      r_l2    <= 1'b0;
      r_l3    <= 1'b0;
      r_l4    <= 1'b0;
      r_s     <= '0;
    end else begin
      r_valid <= in_valid;
      if (in_valid) begin
        r_l1 <= w_l1;
        r_l2 <= w_l2;
        r_l3 <= w_l3;
        r_l4 <= w_l4;
        r_s  <= w_cnt;
      end
    end
  end

  assign out_valid = r_valid;
  assign l1        = r_l1;
  assign l2        = r_l2;
  assign l3        = r_l3;
  assign l4        = r_l4;
  assign s         = r_s;
  assign p         = r_l1;

`ifdef Q3_XCHECK_EN
  logic w_g1, w_g2, w_g3, w_g4;
  logic w_mis;
  logic r_err;

  // Independent gate-level forms of the same four functions.
  assign w_g1  = x ^ y ^ z ^ m;
  assign w_g2  = (x & y & z) | (x & y & m) | (x & z & m) | (y & z & m);
  assign w_g3  = (x & y) | (z & m);
  assign w_g4  = (~x & ~y & z) | (~x & y & m) | (~y & z & m) | (y & ~z & m);
  assign w_mis = (w_g1 ^ w_l1) | (w_g2 ^ w_l2) | (w_g3 ^ w_l3) | (w_g4 ^ w_l4);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_err <= 1'b0;
    end else if (in_valid && w_mis) begin
      r_err <= 1'b1;
    end
  end

  assign err = r_err;
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_q3_fn_bank.sv
// tb_q3_fn_bank: self-checking bench for q3_fn_bank. Table-driven sweep,
// hand-written corner sequences and randomized traffic against a
// behavioural model of the function definitions.
module tb_q3_fn_bank;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic       x, y, z, m;
  logic       out_valid, l1, l2, l3, l4, p, err;
  logic [2:0] s;

  int checks = 0;
  int errors = 0;

  // model of the registered outputs
  logic       mv;
  logic [3:0] ml;   // {l1,l2,l3,l4}
  logic [2:0] ms;

  q3_fn_bank dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid),
    .x(x), .y(y), .z(z), .m(m),
    .out_valid(out_valid), .l1(l1), .l2(l2), .l3(l3), .l4(l4),
    .s(s), .p(p), .err(err)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  typedef struct {
    int         n;
    logic [3:0] l;  // {l1,l2,l3,l4}
    logic [2:0] s;
  } vec_t;

  vec_t tbl [16];

  // Behavioural reference from the function definitions.
  function automatic logic [2:0] ref_s(int n);
    int c = 0;
    for (int i = 0; i < 4; i++) if ((n >> i) & 1) c++;
    return 3'(c);
  endfunction

  function automatic logic [3:0] ref_l(int n);
    int  c;
    bit  f1, f2, f3, f4;
    bit  bx, by, bz, bm;
    c  = int'(ref_s(n));
    bx = ((n >> 3) & 1) != 0;
    by = ((n >> 2) & 1) != 0;
    bz = ((n >> 1) & 1) != 0;
    bm = (n & 1) != 0;
    f1 = (c % 2) == 1;
    f2 = c >= 3;
    f3 = (bx && by) || (bz && bm);
    f4 = (n == 2) || (n == 3) || (n == 5) || (n == 7) || (n == 11) || (n == 13);
    return {f1, f2, f3, f4};
  endfunction

  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, got, exp, $time);
    end
  endtask

  task automatic chk_all(input string tag);
    chk({tag, ".out_valid"}, int'(out_valid), int'(mv));
    chk({tag, ".l1"}, int'(l1), int'(ml[3]));
    chk({tag, ".l2"}, int'(l2), int'(ml[2]));
    chk({tag, ".l3"}, int'(l3), int'(ml[1]));
    chk({tag, ".l4"}, int'(l4), int'(ml[0]));
    chk({tag, ".s"}, int'(s), int'(ms));
    chk({tag, ".p"}, int'(p), int'(ml[3]));
    chk({tag, ".err"}, int'(err), 0);
  endtask

  task automatic model_reset();
    mv = 1'b0; ml = '0; ms = '0;
  endtask

  // One clock: drive inputs, take the edge, update the model, check at +1.
  task automatic cyc(input bit v, input int n, input string tag);
    in_valid = v;
    {x, y, z, m} = 4'(n);
    @(posedge clk);
    mv = v;
    if (v) begin
      ml = ref_l(n);
      ms = ref_s(n);
    end
    #1;
    chk_all(tag);
  endtask

  initial begin
    tbl[0]  = '{0,  4'b0000, 3'd0};
    tbl[1]  = '{1,  4'b1000, 3'd1};
    tbl[2]  = '{2,  4'b1001, 3'd1};
    tbl[3]  = '{3,  4'b0011, 3'd2};
    tbl[4]  = '{4,  4'b1000, 3'd1};
    tbl[5]  = '{5,  4'b0001, 3'd2};
    tbl[6]  = '{6,  4'b0000, 3'd2};
    tbl[7]  = '{7,  4'b1111, 3'd3};
    tbl[8]  = '{8,  4'b1000, 3'd1};
    tbl[9]  = '{9,  4'b0000, 3'd2};
    tbl[10] = '{10, 4'b0000, 3'd2};
    tbl[11] = '{11, 4'b1111, 3'd3};
    tbl[12] = '{12, 4'b0010, 3'd2};
    tbl[13] = '{13, 4'b1111, 3'd3};
    tbl[14] = '{14, 4'b1110, 3'd3};
    tbl[15] = '{15, 4'b0110, 3'd4};

    rst_n = 1'b0; in_valid = 1'b0; {x, y, z, m} = 4'hF;
    model_reset();

    // Reset held: in_valid toggling must not disturb outputs.
    for (int i = 0; i < 4; i++) begin
      in_valid = (i % 2) == 0;
      {x, y, z, m} = 4'(7 + i);
      @(posedge clk); #1;
      chk_all("rst_hold");
    end

    // Release away from the edge; first valid caught at the next edge.
    rst_n = 1'b1;

    // Table sweep n = 0..15 back-to-back.
    for (int i = 0; i < 16; i++) begin
      cyc(1'b1, tbl[i].n, "sweep");
      chk("tbl.l", int'({l1, l2, l3, l4}), int'(tbl[i].l));
      chk("tbl.s", int'(s), int'(tbl[i].s));
    end

    // Gapped valid: n = 12 then 3 idle cycles with junk on the inputs.
    cyc(1'b1, 12, "gap_v");
    chk("gap.l3", int'(l3), 1);
    for (int i = 0; i < 3; i++) begin
      cyc(1'b0, 5 + i, "gap_idle");
      chk("gap.hold_s", int'(s), 2);
    end

    // Back-to-back primes.
    cyc(1'b1, 2,  "b2b"); chk("b2b.s0", int'(s), 1);
    cyc(1'b1, 11, "b2b"); chk("b2b.s1", int'(s), 3);
    cyc(1'b1, 13, "b2b"); chk("b2b.s2", int'(s), 3);
    cyc(1'b0, 0,  "b2b_end");

    // Async assert mid-cycle clears outputs before any edge.
    cyc(1'b1, 7, "pre_async");
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    chk_all("async_clr");
    #1 rst_n = 1'b1;

    // Reset mid-stream: n = 5 presented, reset pulsed before its edge.
    cyc(1'b0, 0, "idle");
    in_valid = 1'b1; {x, y, z, m} = 4'd5;
    #1 rst_n = 1'b0;
    #1 rst_n = 1'b1;
    in_valid = 1'b0;
    model_reset();
    cyc(1'b0, 5, "mid_rst0");
    cyc(1'b0, 5, "mid_rst1");

    // Reset mid-stream after capture: result in flight is dropped.
    cyc(1'b1, 5, "cap5");
    #2 rst_n = 1'b0;
    #2 rst_n = 1'b1;
    model_reset();
    cyc(1'b0, 0, "after_drop");

    // Randomized traffic against the model.
    for (int i = 0; i < 300; i++) begin
      cyc(($urandom_range(0, 9) < 7), int'($urandom_range(0, 15)), "rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
